// File: rtl/tx_scram_par_if.sv
// tx_scram_par_if: byte-stream bus into the SDH transmit scrambler and the
// packed 32-bit FIFO word bus out of it.
//   din/din_valid/din_sof/scramb_en : unscrambled beats, earliest byte in MS lane
//   sdh_gtx_fifo_data/_wen          : packed output word and its write pulse
//   dout_sof                        : word holds frame byte 0 (qualified by wen)
//   frame_err                       : pulse on frame-position resync
//   b1_value/b1_valid               : BIP-8 of previous frame (TX_SCRAM_B1_EN only)
// master = beat source / word sink, slave = scrambler.
interface tx_scram_par_if #(
  parameter int unsigned DW_BYTES = 1
);
  logic [8*DW_BYTES-1:0] din;
  logic                  din_valid;
  logic                  din_sof;
  logic                  scramb_en;
  logic [31:0]           sdh_gtx_fifo_data;
  logic                  sdh_gtx_fifo_wen;
  logic                  dout_sof;
  logic                  frame_err;
`ifdef TX_SCRAM_B1_EN
  logic [7:0]            b1_value;
  logic                  b1_valid;

  modport master (
    output din, din_valid, din_sof, scramb_en,
    input  sdh_gtx_fifo_data, sdh_gtx_fifo_wen, dout_sof, frame_err,
    input  b1_value, b1_valid
  );
  modport slave (
    input  din, din_valid, din_sof, scramb_en,
    output sdh_gtx_fifo_data, sdh_gtx_fifo_wen, dout_sof, frame_err,
    output b1_value, b1_valid
  );
`else
  modport master (
    output din, din_valid, din_sof, scramb_en,
    input  sdh_gtx_fifo_data, sdh_gtx_fifo_wen, dout_sof, frame_err
  );
  modport slave (
    input  din, din_valid, din_sof, scramb_en,
    output sdh_gtx_fifo_data, sdh_gtx_fifo_wen, dout_sof, frame_err
  );
`endif
endinterface

// File: rtl/tx_scram_par.sv
// tx_scram_par: SDH STM-N frame-synchronous scrambler (x^7+x^6+1), DW_BYTES
// bytes per beat, followed by a free-running packer into 32-bit FIFO words.
// Ports:
//   sdh_clk : clock, rising edge
//   rst     : asynchronous active-high reset
//   bus     : tx_scram_par_if.slave (input beats, packed words, frame_err,
//             optional B1)
// Parameters: STM_N (1/4/16), DW_BYTES (1/2/4; 4 only with STM_N>=4).
// Optional feature macro: TX_SCRAM_B1_EN adds a BIP-8 accumulator over the
// post-scrambler bytes and the b1_value/b1_valid outputs.
module tx_scram_par #(
  parameter int unsigned STM_N    = 1,
  parameter int unsigned DW_BYTES = 1
) (
  input  logic          sdh_clk,
  input  logic          rst,
  tx_scram_par_if.slave bus
);

  localparam int unsigned FL  = 2430 * STM_N;
  localparam int unsigned SOH = 9 * STM_N;
  localparam int unsigned CW  = $clog2(FL);
  localparam int unsigned DW  = 8 * DW_BYTES;

  // Eight serial generator steps: returns {keystream byte (MSB first), next state}.
  function automatic logic [14:0] ks_byte(input logic [6:0] s_in);
    logic [6:0] s;
    logic [7:0] ks;
    s  = s_in;
    ks = '0;
    for (int b = 7; b >= 0; b--) begin
      ks[b] = s[6];
      s     = {s[5:0], s[6] ^ s[5]};
    end
    return {ks, s};
  endfunction

  logic [CW-1:0] cnt_q, cnt_d, base_c, pos_c;
  logic [6:0]    scr_q, scr_d, st_c;
  logic          resync_c, wrap_c, sof_lane_c;
  logic [7:0]    kb_c, lane_c;
  logic [DW-1:0] sbytes_c;

  logic          s1_valid_q, s1_sof_q;
  logic [DW-1:0] s1_bytes_q;
  logic          frame_err_q;

  logic [23:0]   pk_q, pk_d;
  logic [2:0]    pk_n_q, pk_n_d, pk_n_c;
  logic          pk_sof_q, pk_sof_d, pk_sof_c;
  logic [31:0]   pk_w_c;
  logic          pk_emit_c;

  logic [31:0]   data_q;
  logic          wen_q, dout_sof_q;

  // Frame position, SOH bypass and per-lane keystream for the current beat.
  // Counter is always a multiple of DW_BYTES, so frame byte 0 lands in lane 0.
  always_comb begin : frame_comb
    resync_c = 1'b0;
    base_c   = cnt_q;
    if (bus.din_sof && (cnt_q != '0)) begin
      resync_c = 1'b1;
      base_c   = '0;
    end
    st_c     = scr_q;
    pos_c    = base_c;
    kb_c     = '0;
    lane_c   = '0;
    sbytes_c = '0;
    for (int k = 0; k < int'(DW_BYTES); k++) begin
      pos_c  = base_c + CW'(k);
      lane_c = bus.din[DW-1-8*k -: 8];
      if (pos_c >= CW'(SOH)) begin
        // generator reloads exactly at the first byte after row-1 SOH
        if (pos_c == CW'(SOH)) st_c = 7'h7F;
        {kb_c, st_c} = ks_byte(st_c);
        if (bus.scramb_en) lane_c = lane_c ^ kb_c;
      end
      sbytes_c[DW-1-8*k -: 8] = lane_c;
    end
    wrap_c     = (base_c == CW'(FL - DW_BYTES));
    cnt_d      = wrap_c ? '0 : base_c + CW'(DW_BYTES);
    scr_d      = st_c;
    sof_lane_c = (base_c == '0);
  end

  // Frame state and the one-cycle scrambled-byte register.
  always_ff @(posedge sdh_clk or posedge rst) begin : frame_reg
    if (rst) begin
      cnt_q       <= '0;
      scr_q       <= 7'h7F;
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_bytes_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      s1_valid_q  <= bus.din_valid;
      frame_err_q <= bus.din_valid & resync_c;
      if (bus.din_valid) begin
        cnt_q      <= cnt_d;
        scr_q      <= scr_d;
        s1_sof_q   <= sof_lane_c;
        s1_bytes_q <= sbytes_c;
      end
    end
  end

  // Packer: shift registered bytes into a word; at most one word per beat
  // because DW_BYTES divides 4 and the fill level stays a multiple of it.
  always_comb begin : pack_comb
    pk_w_c    = {8'h00, pk_q};
    pk_n_c    = pk_n_q;
    pk_emit_c = 1'b0;
    pk_sof_c  = pk_sof_q | s1_sof_q;
    pk_d      = pk_q;
    pk_n_d    = pk_n_q;
    pk_sof_d  = pk_sof_q;
    if (s1_valid_q) begin
      for (int k = 0; k < int'(DW_BYTES); k++) begin
        pk_w_c = {pk_w_c[23:0], s1_bytes_q[DW-1-8*k -: 8]};
        pk_n_c = pk_n_c + 3'd1;
      end
      if (pk_n_c == 3'd4) begin
        pk_emit_c = 1'b1;
        pk_n_d    = 3'd0;
        pk_sof_d  = 1'b0;
      end else begin
        pk_n_d    = pk_n_c;
        pk_sof_d  = pk_sof_c;
      end
      pk_d = pk_w_c[23:0];
    end
  end

  // Packer state and registered FIFO outputs.
  always_ff @(posedge sdh_clk or posedge rst) begin : pack_reg
    if (rst) begin
      pk_q       <= '0;
      pk_n_q     <= '0;
      pk_sof_q   <= 1'b0;
      data_q     <= '0;
      wen_q      <= 1'b0;
      dout_sof_q <= 1'b0;
    end else begin
      pk_q       <= pk_d;
      pk_n_q     <= pk_n_d;
      pk_sof_q   <= pk_sof_d;
      wen_q      <= pk_emit_c;
      dout_sof_q <= pk_emit_c & pk_sof_c;
      if (pk_emit_c) data_q <= pk_w_c;
    end
  end

  assign bus.sdh_gtx_fifo_data = data_q;
  assign bus.sdh_gtx_fifo_wen  = wen_q;
  assign bus.dout_sof          = dout_sof_q;
  assign bus.frame_err         = frame_err_q;

`ifdef TX_SCRAM_B1_EN
  logic [7:0] b1_acc_q, b1_value_q, beat_xor_c;
  logic       b1_valid_q;

  // XOR of all post-scrambler bytes in the current beat.
  always_comb begin : b1_comb
    beat_xor_c = '0;
    for (int k = 0; k < int'(DW_BYTES); k++) begin
      beat_xor_c = beat_xor_c ^ sbytes_c[DW-1-8*k -: 8];
    end
  end

  // A resync closes the old frame before the beat; a wrap closes it after.
  always_ff @(posedge sdh_clk or posedge rst) begin : b1_reg
    if (rst) begin
      b1_acc_q   <= '0;
      b1_value_q <= '0;
      b1_valid_q <= 1'b0;
    end else begin
      b1_valid_q <= 1'b0;
      if (bus.din_valid) begin
        if (resync_c) begin
          b1_value_q <= b1_acc_q;
          b1_valid_q <= 1'b1;
          b1_acc_q   <= beat_xor_c;
        end else if (wrap_c) begin
          b1_value_q <= b1_acc_q ^ beat_xor_c;
          b1_valid_q <= 1'b1;
          b1_acc_q   <= '0;
        end else begin
          b1_acc_q   <= b1_acc_q ^ beat_xor_c;
        end
      end
    end
  end

  assign bus.b1_value = b1_value_q;
  assign bus.b1_valid = b1_valid_q;
`endif

endmodule
